// File: rtl/aes_pkg.sv
// Shared AES definitions for the decryption datapath: GF(2^8) helpers,
// state/column geometry and the iterative engine FSM encoding.
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;
    localparam int         COL_W    = 32;
    localparam int         STATE_W  = 128;
    localparam int         NUM_COLS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_state_e;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

    // Column handled by sub-slot 'sub' during pass 'pass' when 'cpc' columns go per clock.
    function automatic logic [1:0] col_idx(input logic [1:0] pass, input int cpc, input int sub);
        logic [31:0] idx;
        idx = 32'(pass) * 32'(cpc) + 32'(sub);
        return idx[1:0];
    endfunction

endpackage

// File: rtl/inv_mix_columns_seq_col.sv
// Combinational InvMixColumns transform of a single 32-bit column;
// byte 0 of the column is x[31:24].
module inv_mix_column
    import aes_pkg::*;
(
    input  logic [COL_W-1:0] x,
    output logic [COL_W-1:0] y
);

    logic [7:0] a_s  [NUM_COLS];
    logic [7:0] x2_s [NUM_COLS];
    logic [7:0] x4_s [NUM_COLS];
    logic [7:0] x8_s [NUM_COLS];
    logic [7:0] m9_s [NUM_COLS];
    logic [7:0] mb_s [NUM_COLS];
    logic [7:0] md_s [NUM_COLS];
    logic [7:0] me_s [NUM_COLS];

    // Each byte's 09/0b/0d/0e multiples share one xtime chain.
    for (genvar i = 0; i < NUM_COLS; i++) begin : g_byte
        assign a_s[i]  = x[COL_W-1-8*i -: 8];
        assign x2_s[i] = xtime(a_s[i]);
        assign x4_s[i] = xtime(x2_s[i]);
        assign x8_s[i] = xtime(x4_s[i]);
        assign m9_s[i] = x8_s[i] ^ a_s[i];
        assign mb_s[i] = x8_s[i] ^ x2_s[i] ^ a_s[i];
        assign md_s[i] = x8_s[i] ^ x4_s[i] ^ a_s[i];
        assign me_s[i] = x8_s[i] ^ x4_s[i] ^ x2_s[i];
    end

    assign y = {me_s[0] ^ mb_s[1] ^ md_s[2] ^ m9_s[3],
                m9_s[0] ^ me_s[1] ^ mb_s[2] ^ md_s[3],
                md_s[0] ^ m9_s[1] ^ me_s[2] ^ mb_s[3],
                mb_s[0] ^ md_s[1] ^ m9_s[2] ^ me_s[3]};

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Iterative AES InvMixColumns engine: accepts a 128-bit state, transforms
// COLS_PER_CYCLE columns per clock and presents the result over valid/ready.
module inv_mix_columns_seq
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int         N        = NUM_COLS / COLS_PER_CYCLE;
    localparam logic [1:0] LAST_CNT = 2'(N - 1);

    fsm_state_e         state_r;
    fsm_state_e         state_nxt_s;
    logic [STATE_W-1:0] st_r;
    logic [STATE_W-1:0] st_nxt_s;
    logic [STATE_W-1:0] st_upd_s;
    logic [1:0]         cnt_r;
    logic [1:0]         cnt_nxt_s;
    logic               out_valid_r;
    logic               busy_r;
    logic               in_ready_s;

    logic [COL_W-1:0]   st_cols_s  [NUM_COLS];
    logic [COL_W-1:0]   upd_cols_s [NUM_COLS];
    logic [1:0]         col_sel_s  [COLS_PER_CYCLE];
    logic [COL_W-1:0]   col_in_s   [COLS_PER_CYCLE];
    logic [COL_W-1:0]   col_out_s  [COLS_PER_CYCLE];

    for (genvar c = 0; c < NUM_COLS; c++) begin : g_cols
        assign st_cols_s[c] = st_r[STATE_W-1-COL_W*c -: COL_W];
    end

    // One transform lane per column processed in a pass.
    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_lane
        assign col_sel_s[g] = col_idx(cnt_r, COLS_PER_CYCLE, g);
        assign col_in_s[g]  = st_cols_s[col_sel_s[g]];

        inv_mix_column u_col (
            .x (col_in_s[g]),
            .y (col_out_s[g])
        );
    end

    // Splice this pass's transformed columns back into the working state.
    always_comb begin
        upd_cols_s = st_cols_s;
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            upd_cols_s[col_sel_s[g]] = col_out_s[g];
        end
    end

    assign st_upd_s = {upd_cols_s[0], upd_cols_s[1], upd_cols_s[2], upd_cols_s[3]};

    // Next-state, working-register and pass-counter logic.
    always_comb begin
        state_nxt_s = state_r;
        st_nxt_s    = st_r;
        cnt_nxt_s   = cnt_r;
        in_ready_s  = 1'b0;
        case (state_r)
            IDLE: begin
                in_ready_s = 1'b1;
                if (in_valid) begin
                    st_nxt_s    = in_data;
                    cnt_nxt_s   = 2'd0;
                    state_nxt_s = BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                st_nxt_s = st_upd_s;
                if (cnt_r == LAST_CNT) begin
                    state_nxt_s = DONE;
                end else begin
                    cnt_nxt_s = cnt_r + 2'd1;
                end
            end
            DONE: begin
                in_ready_s = out_ready;
                if (out_ready && in_valid) begin
                    st_nxt_s    = in_data;
                    cnt_nxt_s   = 2'd0;
                    state_nxt_s = BUSY;
                end else if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = 2'd0;
            end
        endcase
    end

    // State, working register and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            st_r        <= {STATE_W{1'b0}};
            cnt_r       <= 2'd0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            st_r        <= st_nxt_s;
            cnt_r       <= cnt_nxt_s;
            out_valid_r <= (state_nxt_s == DONE);
            busy_r      <= (state_nxt_s == BUSY);
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign out_data  = st_r;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Self-checking bench: three engine instances (1, 2 and 4 columns per clock)
// compared every cycle against a transaction-level InvMixColumns model.
module tb_inv_mix_columns_seq;

    localparam logic [127:0] FIPS_IN  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
    localparam logic [127:0] FIPS_OUT = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
    localparam logic [127:0] RT_IN    = 128'h4d7ebdf8_4d7ebdf8_4d7ebdf8_4d7ebdf8;
    localparam logic [127:0] RT_OUT   = 128'h2d26314c_2d26314c_2d26314c_2d26314c;
    localparam logic [127:0] C6_ALL   = 128'hc6c6c6c6_c6c6c6c6_c6c6c6c6_c6c6c6c6;
    localparam int           NP [3]   = '{4, 2, 1};

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         iv    [3];
    logic         ordy  [3];
    logic [127:0] idata [3];
    logic         irdy  [3];
    logic         ov    [3];
    logic         bsy   [3];
    logic [127:0] odata [3];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic         m_busy [3];
    logic         m_hold [3];
    int           m_left [3];
    logic [127:0] m_exp  [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    inv_mix_columns_seq #(.COLS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(irdy[0]), .in_data(idata[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(odata[0]), .busy(bsy[0]));
    inv_mix_columns_seq #(.COLS_PER_CYCLE(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(irdy[1]), .in_data(idata[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(odata[1]), .busy(bsy[1]));
    inv_mix_columns_seq #(.COLS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(irdy[2]), .in_data(idata[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(odata[2]), .busy(bsy[2]));

    // Generic shift-and-add GF(2^8) multiply.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Whole-state InvMixColumns via the circulant matrix rows.
    function automatic logic [127:0] ref_imc(input logic [127:0] s);
        logic [7:0]   coef [4];
        logic [7:0]   a [4];
        logic [7:0]   y;
        logic [127:0] r = 128'h0;
        coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) a[j] = s[127 - 32*c - 8*j -: 8];
            for (int i = 0; i < 4; i++) begin
                y = 8'h00;
                for (int j = 0; j < 4; j++) y = y ^ gmul(coef[(j - i + 4) % 4], a[j]);
                r[127 - 32*c - 8*i -: 8] = y;
            end
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Per-cycle comparison of every instance against the transaction model.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                m_busy[k] = 1'b0;
                m_hold[k] = 1'b0;
                m_left[k] = 0;
                check("rst_out_valid", 128'(ov[k]), 128'h0);
                check("rst_busy", 128'(bsy[k]), 128'h0);
                check("rst_out_data", odata[k], 128'h0);
            end else begin
                logic exp_rdy;
                exp_rdy = !m_busy[k] && (!m_hold[k] || ordy[k]);
                check("out_valid", 128'(ov[k]), 128'(m_hold[k]));
                check("busy", 128'(bsy[k]), 128'(m_busy[k]));
                check("in_ready", 128'(irdy[k]), 128'(exp_rdy));
                if (m_hold[k]) check("out_data", odata[k], m_exp[k]);
                if (m_hold[k] && ordy[k]) m_hold[k] = 1'b0;
                if (m_busy[k]) begin
                    m_left[k]--;
                    if (m_left[k] == 0) begin
                        m_busy[k] = 1'b0;
                        m_hold[k] = 1'b1;
                    end
                end
                if (iv[k] && exp_rdy) begin
                    m_exp[k]  = ref_imc(idata[k]);
                    m_busy[k] = 1'b1;
                    m_left[k] = NP[k];
                end
            end
        end
    end

    // Present d until accepted; returns the cycle number of the accepting edge.
    task automatic send(input int k, input logic [127:0] d, output int acc);
        int t = 0;
        idata[k] = d;
        iv[k]    = 1'b1;
        while (irdy[k] !== 1'b1 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 50) check("send_timeout", 128'(irdy[k]), 128'h1);
        @(posedge clk);
        acc = cyc;
        #1;
        iv[k] = 1'b0;
    endtask

    task automatic wait_out(input int k, output logic [127:0] d, output int waited);
        waited = 0;
        while (ov[k] !== 1'b1 && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 50) check("out_timeout", 128'(ov[k]), 128'h1);
        d = odata[k];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] d;
        int acc, prev, w;
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0; ordy[k] = 1'b1; idata[k] = 128'h0;
            m_busy[k] = 1'b0; m_hold[k] = 1'b0; m_left[k] = 0; m_exp[k] = 128'h0;
        end

        // Model anchored to hand-computed vectors.
        check("model_fips", ref_imc(FIPS_IN), FIPS_OUT);
        check("model_roundtrip", ref_imc(RT_IN), RT_OUT);
        check("model_c6", ref_imc(C6_ALL), C6_ALL);

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready_after_reset", 128'(irdy[0]), 128'h1);

        // FIPS vector with backpressure held in DONE.
        ordy[0] = 1'b0;
        send(0, FIPS_IN, acc);
        wait_out(0, d, w);
        check("fips_latency_c1", 128'(w), 128'd4);
        check("fips_data_c1", d, FIPS_OUT);
        idata[0] = RT_IN;
        iv[0]    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("bp_stable", odata[0], FIPS_OUT);
            check("bp_in_ready", 128'(irdy[0]), 128'h0);
            @(posedge clk); #1;
        end
        check("bp_not_accepted", 128'(bsy[0]), 128'h0);
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        check("b2b_busy_next", 128'(bsy[0]), 128'h1);
        wait_out(0, d, w);
        check("roundtrip_data", d, RT_OUT);
        @(posedge clk); #1;

        send(0, C6_ALL, acc);
        wait_out(0, d, w);
        check("c6_data", d, C6_ALL);
        @(posedge clk); #1;

        // Reset while the pass counter sits at 2.
        send(0, FIPS_IN, acc);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 128'(ov[0]), 128'h0);
        check("midrst_busy", 128'(bsy[0]), 128'h0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_in_ready", 128'(irdy[0]), 128'h1);
        send(0, FIPS_IN, acc);
        wait_out(0, d, w);
        check("post_rst_latency", 128'(w), 128'd4);
        check("post_rst_data", d, FIPS_OUT);
        @(posedge clk); #1;

        // Wider configurations on the same vector.
        send(1, FIPS_IN, acc);
        wait_out(1, d, w);
        check("fips_latency_c2", 128'(w), 128'd2);
        check("fips_data_c2", d, FIPS_OUT);
        @(posedge clk); #1;
        send(2, FIPS_IN, acc);
        wait_out(2, d, w);
        check("fips_latency_c4", 128'(w), 128'd1);
        check("fips_data_c4", d, FIPS_OUT);
        @(posedge clk); #1;

        // Back-to-back random states, out_ready tied high.
        for (int k = 0; k < 3; k += 2) begin
            prev = 0;
            for (int i = 0; i < 8; i++) begin
                send(k, {$urandom(), $urandom(), $urandom(), $urandom()}, acc);
                if (i > 0) check("throughput_gap", 128'(acc - prev), 128'(NP[k] + 1));
                prev = acc;
            end
            wait_out(k, d, w);
            @(posedge clk); #1;
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/inv_mix_columns_seq.md
Name: inv_mix_columns_seq

Overview:
- Iterative AES InvMixColumns engine for the decryption datapath; the inverse of the encryption-side MixColumns column transform.
- Accepts one 128-bit state over a valid/ready handshake and processes COLS_PER_CYCLE columns per clock.
- Returns the transformed state over a second valid/ready handshake.
- Sits between InvShiftRows/InvSubBytes and AddRoundKey in the composite decryption round.

Parameters:
- COLS_PER_CYCLE, 1, columns transformed per clock. Legal values are 1, 2 and 4. Pass count N = 4/COLS_PER_CYCLE.

Ports:
- clk  in  1  single clock; all state is updated on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  engine can accept a state.
- in_data  in  128  input state; column c = in_data[127-32c -: 32]; byte 0 of a column is its MSB byte.
- out_valid  out  1  out_data holds a finished state.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  128  transformed state, same column and byte order as in_data.
- busy  out  1  high in BUSY.

Behaviour:
- Per column, over GF(2^8) mod 0x11B:
  - y0 = 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3
  - y1 = 09·a0 ^ 0e·a1 ^ 0b·a2 ^ 0d·a3
  - y2 = 0d·a0 ^ 09·a1 ^ 0e·a2 ^ 0b·a3
  - y3 = 0b·a0 ^ 0d·a1 ^ 09·a2 ^ 0e·a3
- Multiplication is built from an xtime chain: xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1B : 8'h00). 09 = x8^x1, 0b = x8^x2^x1, 0d = x8^x4^x1, 0e = x8^x4^x2.
- Port data is in plain (non-inverted) polarity. Any internal bubble-pushed encoding must be invisible at the ports.
- Internal registers: 128-bit working register st, pass counter cnt (width 2), 2-bit FSM state.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid: st <= in_data, cnt <= 0, go to BUSY.
  - BUSY: each cycle, replace columns cnt*COLS_PER_CYCLE .. +COLS_PER_CYCLE-1 of st with their transform, then cnt <= cnt+1. When cnt = N-1, go to DONE on that same edge.
  - DONE: out_valid=1 and out_data=st.
    - out_ready=1 and in_valid=0: go to IDLE.
    - out_ready=1 and in_valid=1: load the new state, cnt <= 0, go to BUSY (back-to-back operation).
    - out_ready=0: hold; out_data stays stable; in_ready=0.
- in_ready = (state==IDLE) | (state==DONE & out_ready). This is combinational from state and out_ready only; it never depends on in_valid.
- Latency: an input handshake at edge T gives out_valid high after edge T+N. N=4 for COLS_PER_CYCLE=1, N=1 for COLS_PER_CYCLE=4.
- Throughput with out_ready tied high: one state every N+1 cycles.
- in_valid while in BUSY is ignored: no accept and no corruption of st.
- out_data is driven from st in every state. Its value is only meaningful while out_valid=1.
- Asynchronous reset, including mid-operation:
  - State goes to IDLE; st, cnt and out_data go to 0; out_valid and busy go to 0.
  - in_ready goes to 1 in the first cycle after rst_n deasserts.
  - Any partial result is discarded, and no out_valid is produced for it.
- cnt never wraps past N-1; the transition to DONE occurs on the edge where cnt = N-1.

Decomposition:
- Shared package aes_pkg: AES_POLY = 8'h1B; column and state widths (32, 128); function xtime; column-index helper; FSM state enum {IDLE, BUSY, DONE}.
- Sub-module inv_mix_column:
  - Purely combinational, x[31:0] -> y[31:0], byte 0 = x[31:24].
  - It is the decryption-side counterpart of the existing MixColumns column module.
  - COLS_PER_CYCLE instances are generated.
- The top level holds the FSM, counter and column muxing. Expected size is about 150–250 lines.

Test Plan:
- FIPS-197 column vectors through one full state, COLS_PER_CYCLE=1: in_data = 8e4da1bc_9fdc589d_01010101_d5d5d7d6 -> out_data = db135345_f20a225c_01010101_d4d4d4d5, with out_valid rising 4 cycles after accept.
- Round trip: feed the known MixColumns output 4d7ebdf8 (all four columns) -> 2d26314c in every column. Separately, c6c6c6c6 replicated -> unchanged.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_data stable, in_ready=0, a presented in_valid is not accepted. Then release out_ready with in_valid=1 -> new state accepted on the same edge, busy=1 the next cycle.
- Reset mid-operation: assert rst_n=0 asynchronously while cnt=2 -> out_valid=0 and busy=0 immediately, in_ready=1 after release. A fresh vector then completes correctly in 4 cycles.
- COLS_PER_CYCLE=4 and =2, same vector as the first test -> identical out_data at latency 1 and 2 respectively.
- Back-to-back with out_ready tied 1 for 8 random states -> each output matches a software InvMixColumns reference model, at one result every N+1 cycles.
